fir_mac_sched: RTL and testbench

- Time-multiplexed 4-tap FIR engine: one signed multiplier and accumulator, stepped through the taps by a small FSM.
- Accepts input samples with a valid/ready handshake and returns each filtered result with a valid/ready handshake.
- Coefficients are loaded through a write port.
- Sits in the filter path as the sequencing/controller counterpart of the parallel fir_4tap datapath. It trades throughput (one sample per TAPS+2 cycles) for a single multiplier.

---
 rtl/fir_mac_sched.sv | 160 ++++++++++++++++
 tb/tb_fir_mac_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed 4-tap FIR engine.
//   One signed multiplier and one accumulator are stepped through the taps
//   by a three-state FSM (IDLE -> MAC -> DONE). One result is produced per
//   TAPS+2 cycles at best.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   in_valid_i   input sample valid
//   in_ready_o   block can accept a sample (high only in IDLE)
//   xin_i        input sample, signed DW bits
//   coef_we_i    coefficient write strobe (honoured only while not busy)
//   coef_addr_i  coefficient index 0..TAPS-1
//   coef_data_i  coefficient value, signed CW bits
//   out_valid_o  yout_o holds a valid result
//   out_ready_i  downstream accepts the result
//   yout_o       filtered result, signed OW bits
//   busy_o       high whenever the FSM is not in IDLE
//
// Optional feature: define FIR_SAT_EN to saturate the accumulator to the
// signed OW range on output; otherwise the low OW bits are taken (wrap).

module fir_mac_sched #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 16,
    parameter int TAPS = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] xin_i,
    input  logic          coef_we_i,
    input  logic [1:0]    coef_addr_i,
    input  logic [CW-1:0] coef_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] yout_o,
    output logic          busy_o
);

    localparam int PW = DW + CW;
    localparam int AW = DW + CW + 2;
    localparam logic [1:0] LAST_TAP = 2'(TAPS - 1);

`ifdef FIR_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             tap_q, tap_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [DW-1:0]   x_q [TAPS];
    logic signed [DW-1:0]   x_d [TAPS];
    logic signed [CW-1:0]   h_q [TAPS];
    logic signed [CW-1:0]   h_d [TAPS];
    logic [OW-1:0]          yout_q, yout_d;
    logic                   ov_q, ov_d;

    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   sum;

    // Full-precision product of the current tap, sign-extended into the
    // accumulator width.
    assign prod = h_q[tap_q] * x_q[tap_q];
    assign sum  = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        x_d     = x_q;
        h_d     = h_q;
        yout_d  = yout_q;
        ov_d    = ov_q;

        unique case (state_q)
            IDLE: begin
                // A write landing on the accept edge is seen by this sample:
                // MAC first reads h on the following edge.
                if (coef_we_i && (int'(coef_addr_i) < TAPS))
                    h_d[coef_addr_i] = coef_data_i;
                if (in_valid_i) begin
                    x_d[0] = xin_i;
                    for (int unsigned k = 1; k < TAPS; k++)
                        x_d[k] = x_q[k-1];
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                tap_d = tap_q + 2'd1;
                if (tap_q == LAST_TAP) begin
                    // Final sum goes straight into the output register.
`ifdef FIR_SAT_EN
                    if (sum > SAT_MAX)
                        yout_d = SAT_MAX[OW-1:0];
                    else if (sum < SAT_MIN)
                        yout_d = SAT_MIN[OW-1:0];
                    else
                        yout_d = sum[OW-1:0];
`else
                    yout_d = sum[OW-1:0];
`endif
                    ov_d    = 1'b1;
                    tap_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tap_q   <= '0;
            acc_q   <= '0;
            yout_q  <= '0;
            ov_q    <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            yout_q  <= yout_d;
            ov_q    <= ov_d;
            x_q     <= x_d;
            h_q     <= h_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = ov_q;
    assign yout_o      = yout_q;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched. A behavioural model (coefficient
// and delay-line arrays, plain integer dot product) predicts every result.
module tb_fir_mac_sched;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        xin = '0;
    logic              coef_we = 1'b0;
    logic [1:0]        coef_addr = '0;
    logic [7:0]        coef_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [15:0] yout;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    int mh [4];
    int mx [4];

    fir_mac_sched #(.DW(8), .CW(8), .OW(16), .TAPS(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .xin_i       (xin),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .yout_o      (yout),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int conv(input int s);
        logic [31:0] t;
`ifdef FIR_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        t = s;
        return int'($signed(t[15:0]));
`endif
    endfunction

    function automatic int model_y();
        int s = 0;
        for (int k = 0; k < 4; k++) s += mh[k] * mx[k];
        return conv(s);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mh[k] = 0;
            mx[k] = 0;
        end
    endtask

    task automatic model_shift(input int v);
        for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
    endtask

    // ---------------- drivers (all start and end just after a negedge) ----
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(d);
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        mh[a] = d;
    endtask

    // Send one sample. we_at: -1 none, 0 write together with the accept,
    // n>0 write on the n-th cycle after the accept. Returns the result, the
    // number of cycles until out_valid, whether in_ready/busy stayed
    // low/high until then, whether the result held stable during the stall,
    // and in_ready/out_valid the cycle after the handoff.
    task automatic run_sample(input int xv, input int stall, input int we_at,
                              input int wa, input int wd,
                              output int y, output int lat, output bit hs_ok,
                              output bit stable_ok, output logic post_ov,
                              output logic post_rdy);
        int n;
        in_valid = 1'b1; xin = 8'(xv);
        if (we_at == 0) begin
            coef_we = 1'b1; coef_addr = 2'(wa); coef_data = 8'(wd);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        hs_ok = 1'b1;
        lat = 99;
        for (n = 1; n <= 20; n++) begin
            coef_we = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready || !busy) hs_ok = 1'b0;
            if (n == we_at) begin
                coef_we = 1'b1; coef_addr = 2'(wa); coef_data = 8'(wd);
            end
            @(negedge clk);
        end
        coef_we = 1'b0;
        y = int'(yout);
        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!out_valid || int'(yout) != y || in_ready || !busy)
                stable_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        post_ov  = out_valid;
        post_rdy = in_ready;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010 || yout !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_state: ov/rdy/busy=%b yout=%0d required 010 yout=0",
                     {out_valid, in_ready, busy}, yout);
        end
        do_reset();
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010 || yout !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_release: ov/rdy/busy=%b yout=%0d required 010 yout=0",
                     {out_valid, in_ready, busy}, yout);
        end
    endtask

    task automatic test_basic();
        int xs [4] = '{-3, 1, 0, -2};
        int req [4] = '{-3, -5, -7, -11};
        int y, lat, exp_y;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, k + 1);
        for (int i = 0; i < 4; i++) begin
            model_shift(xs[i]);
            exp_y = model_y();
            run_sample(xs[i], 0, -1, 0, 0, y, lat, hs, st, pov, prdy);
            n_checks++;
            if (y !== exp_y || y !== req[i]) begin
                n_fail++;
                $display("FAIL basic_y[%0d]: got %0d required %0d", i, y, req[i]);
            end
            n_checks++;
            if (lat !== 5 || !hs) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d cycles hs_ok=%0b required 5 cycles hs_ok=1",
                         i, lat, hs);
            end
            n_checks++;
            if (pov !== 1'b0 || prdy !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_handoff[%0d]: ov=%b rdy=%b required ov=0 rdy=1", i, pov, prdy);
            end
        end
    endtask

    task automatic test_saturation();
        int y, lat, exp_y, fourth;
        bit hs, st;
        logic pov, prdy;
`ifdef FIR_SAT_EN
        fourth = 32767;
`else
        fourth = 0;
`endif
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, -128);
        for (int i = 0; i < 4; i++) begin
            model_shift(-128);
            exp_y = model_y();
            run_sample(-128, 0, -1, 0, 0, y, lat, hs, st, pov, prdy);
            n_checks++;
            if (y !== exp_y) begin
                n_fail++;
                $display("FAIL sat_y[%0d]: got %0d required %0d", i, y, exp_y);
            end
        end
        n_checks++;
        if (y !== fourth) begin
            n_fail++;
            $display("FAIL sat_fourth: got %0d required %0d", y, fourth);
        end
    endtask

    task automatic test_backpressure();
        int y, lat, exp_y;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, k + 1);
        model_shift(9);
        exp_y = model_y();
        run_sample(9, 10, -1, 0, 0, y, lat, hs, st, pov, prdy);
        n_checks++;
        if (y !== exp_y || !st) begin
            n_fail++;
            $display("FAIL backpressure_hold: y=%0d stable=%0b required y=%0d stable=1", y, st, exp_y);
        end
        n_checks++;
        if (pov !== 1'b0 || prdy !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: ov=%b rdy=%b required ov=0 rdy=1", pov, prdy);
        end
    endtask

    task automatic test_coef_busy();
        int y, lat, exp_y;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, k + 1);
        model_shift(3);
        exp_y = model_y();
        run_sample(3, 0, 2, 0, 100, y, lat, hs, st, pov, prdy);
        n_checks++;
        if (y !== exp_y) begin
            n_fail++;
            $display("FAIL coef_busy_ignored: got %0d required %0d", y, exp_y);
        end
        write_coef(0, 100);
        model_shift(3);
        exp_y = model_y();
        run_sample(3, 0, -1, 0, 0, y, lat, hs, st, pov, prdy);
        n_checks++;
        if (y !== exp_y) begin
            n_fail++;
            $display("FAIL coef_idle_applied: got %0d required %0d", y, exp_y);
        end
    endtask

    task automatic test_reset_mid();
        int y, lat, exp_y;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, k + 1);
        in_valid = 1'b1; xin = 8'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: ov=%b rdy=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        model_shift(5);
        exp_y = model_y();
        run_sample(5, 0, -1, 0, 0, y, lat, hs, st, pov, prdy);
        n_checks++;
        if (y !== exp_y || y !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_coefs_cleared: got %0d required 0", y);
        end
    endtask

    task automatic test_simultaneous();
        int y, lat, exp_y;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        mh[0] = 7;
        model_shift(2);
        exp_y = model_y();
        run_sample(2, 0, 0, 0, 7, y, lat, hs, st, pov, prdy);
        n_checks++;
        if (y !== exp_y || y !== 14) begin
            n_fail++;
            $display("FAIL simultaneous_write: got %0d required 14", y);
        end
    endtask

    task automatic test_random();
        int y, lat, exp_y, xv, stall;
        bit hs, st;
        logic pov, prdy;
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(k, int'($urandom_range(255)) - 128);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(3) == 0)
                write_coef(int'($urandom_range(3)), int'($urandom_range(255)) - 128);
            xv = int'($urandom_range(255)) - 128;
            stall = int'($urandom_range(3));
            model_shift(xv);
            exp_y = model_y();
            // Writes attempted mid-computation must not disturb the model.
            run_sample(xv, stall, ($urandom_range(1) == 1) ? int'($urandom_range(1, 4)) : -1,
                       int'($urandom_range(3)), int'($urandom_range(255)),
                       y, lat, hs, st, pov, prdy);
            n_checks++;
            if (y !== exp_y || lat !== 5 || !hs || !st || pov !== 1'b0 || prdy !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d]: y=%0d lat=%0d hs=%0b st=%0b ov=%b rdy=%b required y=%0d lat=5 1 1 0 1",
                         i, y, lat, hs, st, pov, prdy, exp_y);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_coef_busy();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
